noise_lane_arbiter: RTL and testbench

NOISE_LANE_ARBITER -- requirements
Module: noise_lane_arbiter

---
 rtl/noise_lane_arbiter.sv | 154 +++++++++++++++
 tb/tb_noise_lane_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/noise_lane_arbiter.sv
// Shares one noise generator among NUM_LANES requesters, granting bursts round-robin.
// Latency: req in IDLE -> grant/gen_en next cycle; noise_in -> noise_out one cycle later.
// Backpressure: a granted lane stalls by holding noise_in_valid low; dropping req ends the burst.
module noise_lane_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_LANES-1:0]     req,
  input  logic signed [DATA_W-1:0] noise_in,
  input  logic                     noise_in_valid,
  output logic                     gen_en,
  output logic [NUM_LANES-1:0]     grant,
  output logic signed [DATA_W-1:0] noise_out,
  output logic [NUM_LANES-1:0]     noise_out_valid,
  output logic                     busy
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  // After reset the pointer sits on the last lane so lane 0 is searched first.
  localparam logic [LANE_W-1:0] LAST_LANE_RST = LANE_W'(NUM_LANES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST      = CNT_W'(BURST_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [NUM_LANES-1:0]      grant_q, grant_d;
  logic [LANE_W-1:0]         gnt_idx_q, gnt_idx_d;
  logic [LANE_W-1:0]         last_lane_q, last_lane_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [DATA_W-1:0]  nout_q, nout_d;
  logic [NUM_LANES-1:0]      nvld_q, nvld_d;

  logic                      pick_vld;
  logic [LANE_W-1:0]         pick_idx;
  logic [LANE_W-1:0]         cand_idx;
  logic [NUM_LANES-1:0]      pick_oh;
  logic                      gnt_req;
  int                        cand;

  // Round-robin search from last_lane+1; scanning offsets downward lets the nearest requester win.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_idx = '0;
    cand     = 0;
    for (int i = NUM_LANES; i >= 1; i--) begin
      cand     = (int'(last_lane_q) + i) % NUM_LANES;
      cand_idx = LANE_W'(cand);
      if (req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  // One-hot form of the selected lane.
  always_comb begin
    pick_oh = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      pick_oh[l] = (pick_idx == LANE_W'(l));
    end
  end

  // The granted lane is still asking for samples.
  assign gnt_req = |(req & grant_q);

  // Next-state and datapath decisions; every burst exit records the lane for fairness.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gnt_idx_d   = gnt_idx_q;
    last_lane_d = last_lane_q;
    cnt_d       = cnt_q;
    nout_d      = nout_q;
    nvld_d      = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d   = SERVE;
          grant_d   = pick_oh;
          gnt_idx_d = pick_idx;
          cnt_d     = '0;
        end
      end
      SERVE: begin
        if (!gnt_req) begin
          // Lane withdrew: any sample offered this cycle is dropped.
          state_d     = IDLE;
          grant_d     = '0;
          last_lane_d = gnt_idx_q;
          cnt_d       = '0;
        end else if (noise_in_valid) begin
          nout_d = noise_in;
          nvld_d = grant_q;
          if (cnt_q == CNT_LAST) begin
            state_d     = IDLE;
            grant_d     = '0;
            last_lane_d = gnt_idx_q;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant, burst bookkeeping and output sample registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q     <= '0;
      gnt_idx_q   <= '0;
      last_lane_q <= LAST_LANE_RST;
      cnt_q       <= '0;
      nout_q      <= '0;
      nvld_q      <= '0;
    end else begin
      grant_q     <= grant_d;
      gnt_idx_q   <= gnt_idx_d;
      last_lane_q <= last_lane_d;
      cnt_q       <= cnt_d;
      nout_q      <= nout_d;
      nvld_q      <= nvld_d;
    end
  end

  assign gen_en          = (state_q == SERVE);
  assign busy            = (state_q == SERVE);
  assign grant           = grant_q;
  assign noise_out       = nout_q;
  assign noise_out_valid = nvld_q;

  // Grant and per-lane valid never name more than one lane.
  a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_valid_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(noise_out_valid));

endmodule

// File: tb/tb_noise_lane_arbiter.sv
// Directed bench for noise_lane_arbiter with default parameters (4 lanes, 8-bit, bursts of 4).
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_noise_lane_arbiter;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [7:0]       noise_in;
  logic             noise_in_valid;
  logic             gen_en;
  logic [3:0]       grant;
  logic [7:0]       noise_out;
  logic [3:0]       noise_out_valid;
  logic             busy;

  int n_checks;
  int n_fail;

  noise_lane_arbiter #(
    .NUM_LANES(4),
    .DATA_W(8),
    .BURST_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .noise_in(noise_in),
    .noise_in_valid(noise_in_valid),
    .gen_en(gen_en),
    .grant(grant),
    .noise_out(noise_out),
    .noise_out_valid(noise_out_valid),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    noise_in = 8'h00;
    noise_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (gen_en !== 1'b0) begin n_fail++; $display("FAIL reset_gen_en: got %b expected 0", gen_en); end
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (noise_out !== 8'h00) begin n_fail++; $display("FAIL reset_noise_out: got %h expected 00", noise_out); end
    n_checks++; if (noise_out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", noise_out_valid); end
  endtask

  task automatic test_basic_burst();
    logic [7:0] s [4] = '{8'h05, 8'hFB, 8'h7F, 8'h80};
    do_reset();
    req = 4'b1010;
    tick();
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL basic_grant: got %b expected 0010", grant); end
    n_checks++; if (gen_en !== 1'b1) begin n_fail++; $display("FAIL basic_gen_en: got %b expected 1", gen_en); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
    for (int k = 0; k < 4; k++) begin
      noise_in = s[k];
      noise_in_valid = 1'b1;
      tick();
      n_checks++; if (noise_out_valid !== 4'b0010) begin n_fail++; $display("FAIL basic_valid[%0d]: got %b expected 0010", k, noise_out_valid); end
      n_checks++; if (noise_out !== s[k]) begin n_fail++; $display("FAIL basic_data[%0d]: got %h expected %h", k, noise_out, s[k]); end
    end
    n_checks++; if (gen_en !== 1'b0) begin n_fail++; $display("FAIL basic_end_gen_en: got %b expected 0", gen_en); end
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL basic_end_grant: got %b expected 0000", grant); end
    req = 4'b0000;
    noise_in_valid = 1'b0;
    noise_in = 8'h3C;
    tick();
    n_checks++; if (noise_out_valid !== 4'b0000) begin n_fail++; $display("FAIL basic_valid_pulse: got %b expected 0000", noise_out_valid); end
    n_checks++; if (noise_out !== 8'h80) begin n_fail++; $display("FAIL basic_hold: got %h expected 80", noise_out); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] v;
    do_reset();
    req = 4'b1111;
    noise_in_valid = 1'b1;
    tick();
    n_checks++; if (grant !== exp_g[0]) begin n_fail++; $display("FAIL rr_first_grant: got %b expected %b", grant, exp_g[0]); end
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) begin
        v = 8'(b * 16 + k + 1);
        noise_in = v;
        tick();
        n_checks++; if (noise_out_valid !== exp_g[b]) begin n_fail++; $display("FAIL rr_valid b%0d k%0d: got %b expected %b", b, k, noise_out_valid, exp_g[b]); end
        n_checks++; if (noise_out !== v) begin n_fail++; $display("FAIL rr_data b%0d k%0d: got %h expected %h", b, k, noise_out, v); end
        if (k < 3) begin
          n_checks++; if (grant !== exp_g[b]) begin n_fail++; $display("FAIL rr_hold b%0d k%0d: got %b expected %b", b, k, grant, exp_g[b]); end
        end else begin
          n_checks++; if (grant !== 4'b0000 || gen_en !== 1'b0) begin n_fail++; $display("FAIL rr_idle b%0d: got grant %b gen_en %b expected 0000 0", b, grant, gen_en); end
        end
      end
      if (b < 4) begin
        tick();
        n_checks++; if (grant !== exp_g[b+1]) begin n_fail++; $display("FAIL rr_grant b%0d: got %b expected %b", b + 1, grant, exp_g[b+1]); end
        n_checks++; if (noise_out_valid !== 4'b0000) begin n_fail++; $display("FAIL rr_gap_valid b%0d: got %b expected 0000", b, noise_out_valid); end
      end
    end
    req = 4'b0000;
    noise_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_early_term();
    do_reset();
    req = 4'b0100;
    tick();
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL et_grant: got %b expected 0100", grant); end
    noise_in = 8'h11; noise_in_valid = 1'b1;
    tick();
    n_checks++; if (noise_out_valid !== 4'b0100 || noise_out !== 8'h11) begin n_fail++; $display("FAIL et_s1: got %b %h expected 0100 11", noise_out_valid, noise_out); end
    noise_in = 8'h22;
    tick();
    n_checks++; if (noise_out_valid !== 4'b0100 || noise_out !== 8'h22) begin n_fail++; $display("FAIL et_s2: got %b %h expected 0100 22", noise_out_valid, noise_out); end
    // Lane 2 withdraws while other lanes ask and a sample is offered.
    req = 4'b1011; noise_in = 8'h33;
    tick();
    n_checks++; if (noise_out_valid !== 4'b0000) begin n_fail++; $display("FAIL et_drop_valid: got %b expected 0000", noise_out_valid); end
    n_checks++; if (noise_out !== 8'h22) begin n_fail++; $display("FAIL et_drop_data: got %h expected 22", noise_out); end
    n_checks++; if (gen_en !== 1'b0 || grant !== 4'b0000) begin n_fail++; $display("FAIL et_idle: got gen_en %b grant %b expected 0 0000", gen_en, grant); end
    tick();
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL et_next_grant: got %b expected 1000", grant); end
    req = 4'b0000; noise_in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_valid_gaps();
    logic p [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] v;
    int nv;
    nv = 0;
    do_reset();
    req = 4'b0001;
    tick();
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL gap_grant: got %b expected 0001", grant); end
    for (int i = 0; i < 7; i++) begin
      v = 8'(8'h40 + i);
      noise_in = v;
      noise_in_valid = p[i];
      tick();
      if (p[i]) begin
        nv++;
        n_checks++; if (noise_out_valid !== 4'b0001 || noise_out !== v) begin n_fail++; $display("FAIL gap_valid[%0d]: got %b %h expected 0001 %h", i, noise_out_valid, noise_out, v); end
      end else begin
        n_checks++; if (noise_out_valid !== 4'b0000) begin n_fail++; $display("FAIL gap_novalid[%0d]: got %b expected 0000", i, noise_out_valid); end
      end
      if (i < 6) begin
        n_checks++; if (gen_en !== 1'b1) begin n_fail++; $display("FAIL gap_gen_en[%0d]: got %b expected 1", i, gen_en); end
      end
    end
    n_checks++; if (gen_en !== 1'b0) begin n_fail++; $display("FAIL gap_end_gen_en: got %b expected 0", gen_en); end
    n_checks++; if (nv !== 4) begin n_fail++; $display("FAIL gap_count: got %0d expected 4", nv); end
    req = 4'b0000; noise_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b0010;
    tick();
    noise_in = 8'hA1; noise_in_valid = 1'b1;
    tick();
    noise_in = 8'hA2;
    tick();
    n_checks++; if (noise_out_valid !== 4'b0010 || noise_out !== 8'hA2) begin n_fail++; $display("FAIL mid_pre: got %b %h expected 0010 a2", noise_out_valid, noise_out); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (gen_en !== 1'b0 || busy !== 1'b0 || grant !== 4'b0000) begin n_fail++; $display("FAIL mid_async_ctrl: got gen_en %b busy %b grant %b expected 0 0 0000", gen_en, busy, grant); end
    n_checks++; if (noise_out !== 8'h00 || noise_out_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_async_data: got %h %b expected 00 0000", noise_out, noise_out_valid); end
    tick();
    rst = 1'b0;
    req = 4'b1000;
    tick();
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL mid_regrant: got %b expected 1000", grant); end
    n_checks++; if (noise_out_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_no_valid: got %b expected 0000", noise_out_valid); end
    req = 4'b0000; noise_in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_idle_valid();
    do_reset();
    noise_in = 8'h55;
    noise_in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++; if (gen_en !== 1'b0 || noise_out_valid !== 4'b0000) begin n_fail++; $display("FAIL idle_valid[%0d]: got gen_en %b valid %b expected 0 0000", c, gen_en, noise_out_valid); end
    end
    n_checks++; if (noise_out !== 8'h00) begin n_fail++; $display("FAIL idle_data: got %h expected 00", noise_out); end
    noise_in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    req = 4'b0000;
    noise_in = 8'h00;
    noise_in_valid = 1'b0;
    test_reset();
    test_basic_burst();
    test_round_robin();
    test_early_term();
    test_valid_gaps();
    test_reset_mid_burst();
    test_idle_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
